pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst  in  1  reset; asynchronous, active-high.
REQ-003 SHALL have port start  in  1  begin execution from IDLE.
REQ-004 SHALL have port pc_cur  in  8  current PC, taken from the PC register output.
REQ-005 SHALL have port next_pc  out  8  value the PC register loads on every clk edge.
REQ-006 SHALL have port fetch_req  out  1  instruction fetch request.
REQ-007 SHALL have port fetch_addr  out  8  fetch address.
REQ-008 SHALL have port fetch_ack  in  1  fetch complete; instruction valid this cycle.
REQ-009 SHALL have port instr_load  out  1  one-cycle load strobe for the instruction register.
REQ-010 SHALL have port is_halt, is_jump, is_branch, br_cond  in  1 each  decoded instruction class, valid in EXEC.
REQ-011 SHALL have port target  in  8  jump absolute address / branch signed offset.
REQ-012 SHALL have port stall  in  1  hold EXEC.
REQ-013 SHALL have ports halted  out  1  and  retired  out  16  (halt flag, retired-instruction count).
REQ-014 SHALL have port state  out  2  FSM state for debug.

Function
REQ-015 SHALL implement FSM IDLE=00, FETCH=01, EXEC=10, HALT=11.
REQ-016 IDLE: next_pc=pc_cur, fetch_req=0; start=1 -> FETCH next edge.
REQ-017 FETCH: fetch_req=1, fetch_addr=pc_cur, next_pc=pc_cur.
- fetch_ack=1 -> instr_load=1 in the same cycle; move to EXEC.
- fetch_ack=0 -> stay in FETCH; fetch_req stays 1.
REQ-018 fetch_addr SHALL equal pc_cur in all states; fetch_ack outside FETCH SHALL be ignored.
REQ-019 EXEC with stall=1: state held, next_pc=pc_cur, retired unchanged.
REQ-020 EXEC with stall=0: next_pc is chosen by this priority (first match wins):
- is_halt: pc_cur; go to HALT.
- is_jump: target.
- is_branch & br_cond: pc_cur+1+sign-extended target.
- otherwise: pc_cur+1.
- Non-halt cases go to FETCH.
REQ-021 All PC arithmetic SHALL be modulo 256 (0xFF+1 -> 0x00; 0x05+1+0xF0 -> 0xF6).
REQ-022 is_branch with br_cond=0 SHALL yield pc_cur+1.
REQ-023 retired SHALL increment by 1 on each non-stalled EXEC cycle, halt included, and saturate at 0xFFFF.
REQ-024 HALT: next_pc=pc_cur, fetch_req=0, halted=1; start is ignored; exit only by rst.
REQ-025 start SHALL be ignored outside IDLE.
REQ-026 Only the state register, the halted register and the retired counter SHALL be sequential; next_pc, fetch_req and instr_load SHALL be combinational from state and inputs.
REQ-027 Each instruction SHALL take at least 2 cycles (FETCH with ack, then EXEC); fetch wait states and stalls add 1 cycle each.

Reset
REQ-028 rst=1 SHALL immediately force state=IDLE, halted=0, retired=0, fetch_req=0, instr_load=0, independent of clk.
REQ-029 With state=IDLE, next_pc SHALL equal pc_cur (0x00 under reset, since the PC register shares rst).
REQ-030 rst asserted mid-FETCH or mid-EXEC SHALL abandon the instruction; retired is not incremented.
REQ-031 After rst deasserts, the FSM SHALL remain in IDLE until start.

Structure
REQ-032 SHALL place the state encodings, PC_W=8, CNT_W=16 and RESET_PC=8'h00 in shared package pc_seq_pkg.
REQ-033 SHALL place next-PC selection and the adders in one combinational sub-module pc_next_calc.
REQ-034 The PC register SHALL stay external; pc_sequencer drives its input and reads its output.

Verification
REQ-035 Reset, start, 3 plain instructions, ack on first FETCH cycle -> fetch_addr 0x00, 0x01, 0x02; retired=3; 2 cycles per instruction.
REQ-036 At pc=0x10, is_jump with target=0x80 -> next fetch_addr=0x80; at pc=0x05, is_branch, br_cond=1, target=0xF0 -> 0xF6; same with br_cond=0 -> 0x06.
REQ-037 pc=0xFF plain instruction -> next fetch_addr=0x00 (wrap-around).
REQ-038 fetch_ack delayed 3 cycles and stall=1 for 2 EXEC cycles -> pc held, fetch_req steady, instr_load a single pulse, retired +1 only.
REQ-039 is_halt together with is_jump -> halt wins: state=HALT, halted=1, pc frozen; start pulse ignored.
REQ-040 rst asserted mid-FETCH between clock edges -> fetch_req=0 before the next edge, state=IDLE, retired=0.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared widths, reset PC and FSM encoding for the PC sequencer.
package pc_seq_pkg;

  localparam int unsigned PC_W  = 8;
  localparam int unsigned CNT_W = 16;

  localparam logic [PC_W-1:0]  RESET_PC = 8'h00;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_FETCH = 2'b01,
    S_EXEC  = 2'b10,
    S_HALT  = 2'b11
  } seq_state_e;

  // Sequential successor of a PC, wrapping modulo 2**PC_W.
  function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc);
    return pc + PC_W'(1);
  endfunction

endpackage

// File: rtl/pc_next_calc.sv
// Next-PC selection: hold, halt, jump, taken branch or sequential step.
module pc_next_calc
  import pc_seq_pkg::*;
(
  input  logic            advance,
  input  logic            is_halt,
  input  logic            is_jump,
  input  logic            is_branch,
  input  logic            br_cond,
  input  logic [PC_W-1:0] pc_cur,
  input  logic [PC_W-1:0] target,
  output logic [PC_W-1:0] next_pc
);

  logic [PC_W-1:0] pc_seq;
  logic [PC_W-1:0] pc_br;

  // Offset is as wide as the PC, so sign extension vanishes modulo 2**PC_W.
  assign pc_seq = pc_inc(pc_cur);
  assign pc_br  = pc_seq + target;

  always_comb begin
    next_pc = pc_cur;
    if (advance) begin
      if (is_halt) begin
        next_pc = pc_cur;
      end else if (is_jump) begin
        next_pc = target;
      end else if (is_branch && br_cond) begin
        next_pc = pc_br;
      end else begin
        next_pc = pc_seq;
      end
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch/execute sequencer driving an external PC register and an instruction fetch port.
module pc_sequencer
  import pc_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [PC_W-1:0]  pc_cur,
  output logic [PC_W-1:0]  next_pc,
  output logic             fetch_req,
  output logic [PC_W-1:0]  fetch_addr,
  input  logic             fetch_ack,
  output logic             instr_load,
  input  logic             is_halt,
  input  logic             is_jump,
  input  logic             is_branch,
  input  logic             br_cond,
  input  logic [PC_W-1:0]  target,
  input  logic             stall,
  output logic             halted,
  output logic [CNT_W-1:0] retired,
  output logic [1:0]       state
);

  seq_state_e st;
  logic       advance;

  // Fetch-side strobes decode straight from state so a reset clears them without a clock.
  assign advance    = (st == S_EXEC) && !stall;
  assign fetch_req  = (st == S_FETCH);
  assign instr_load = fetch_req && fetch_ack;
  assign fetch_addr = pc_cur;
  assign state      = st;

  pc_next_calc u_next (
    .advance   (advance),
    .is_halt   (is_halt),
    .is_jump   (is_jump),
    .is_branch (is_branch),
    .br_cond   (br_cond),
    .pc_cur    (pc_cur),
    .target    (target),
    .next_pc   (next_pc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st      <= S_IDLE;
      halted  <= 1'b0;
      retired <= '0;
    end else begin
      case (st)
        S_IDLE: begin
          if (start) st <= S_FETCH;
        end
        S_FETCH: begin
          if (fetch_ack) st <= S_EXEC;
        end
        S_EXEC: begin
          if (!stall) begin
            // Halt retires like any other instruction; the count sticks at its maximum.
            if (retired != CNT_MAX) retired <= retired + CNT_W'(1);
            if (is_halt) begin
              st     <= S_HALT;
              halted <= 1'b1;
            end else begin
              st <= S_FETCH;
            end
          end
        end
        S_HALT: begin
          st <= S_HALT;
        end
        default: begin
          st <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: decode vector table, hand-built corner sequences and a random program.
module tb_pc_sequencer;
  import pc_seq_pkg::*;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  pc;
  logic [7:0]  next_pc;
  logic        fetch_req;
  logic [7:0]  fetch_addr;
  logic        fetch_ack;
  logic        instr_load;
  logic        is_halt, is_jump, is_branch, br_cond;
  logic [7:0]  target;
  logic        stall;
  logic        halted;
  logic [15:0] retired;
  logic [1:0]  state;

  logic        pc_wr;
  logic [7:0]  pc_wr_val;

  int checks   = 0;
  int failures = 0;
  int m_pc;
  int m_ret;

  pc_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .pc_cur     (pc),
    .next_pc    (next_pc),
    .fetch_req  (fetch_req),
    .fetch_addr (fetch_addr),
    .fetch_ack  (fetch_ack),
    .instr_load (instr_load),
    .is_halt    (is_halt),
    .is_jump    (is_jump),
    .is_branch  (is_branch),
    .br_cond    (br_cond),
    .target     (target),
    .stall      (stall),
    .halted     (halted),
    .retired    (retired),
    .state      (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External PC register; pc_wr lets the bench preload it while the sequencer idles.
  always @(posedge clk or posedge rst) begin
    if (rst) pc <= RESET_PC;
    else if (pc_wr) pc <= pc_wr_val;
    else pc <= next_pc;
  end

  typedef struct {
    logic [7:0] pc;
    logic       h, j, b, c;
    logic [7:0] tg;
    logic [7:0] exp_next;
    logic [1:0] exp_state;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_decode();
    is_halt = 0; is_jump = 0; is_branch = 0; br_cond = 0; target = 8'h00; stall = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    @(negedge clk);
    rst = 0;
    m_pc = 0;
    m_ret = 0;
  endtask

  task automatic set_pc(input logic [7:0] p);
    pc_wr = 1; pc_wr_val = p;
    @(negedge clk);
    pc_wr = 0;
    m_pc = int'(p);
  endtask

  task automatic go();
    start = 1;
    @(negedge clk);
    start = 0;
  endtask

  // Runs one instruction starting in FETCH; expectations come from the instruction rules.
  task automatic run_instr(input int dly, input int stl, input logic h, input logic j,
                           input logic b, input logic c, input logic [7:0] tg);
    int exp_pc;
    int cyc;
    cyc = 0;
    if (h) exp_pc = m_pc;
    else if (j) exp_pc = int'(tg);
    else if (b && c) exp_pc = (m_pc + 1 + int'($signed(tg))) & 255;
    else exp_pc = (m_pc + 1) & 255;

    for (int k = 0; k < dly; k++) begin
      fetch_ack = 0;
      #1;
      chk("wait_req", 32'(fetch_req), 1);
      chk("wait_load", 32'(instr_load), 0);
      chk("wait_addr", 32'(fetch_addr), m_pc);
      chk("wait_hold", 32'(next_pc), m_pc);
      @(negedge clk); cyc++;
    end
    fetch_ack = 1;
    #1;
    chk("fetch_req", 32'(fetch_req), 1);
    chk("fetch_addr", 32'(fetch_addr), m_pc);
    chk("instr_load", 32'(instr_load), 1);
    @(negedge clk); cyc++;

    is_halt = h; is_jump = j; is_branch = b; br_cond = c; target = tg;
    for (int k = 0; k < stl; k++) begin
      stall = 1;
      fetch_ack = 1;
      #1;
      chk("stall_pc", 32'(next_pc), m_pc);
      chk("stall_ret", 32'(retired), m_ret);
      chk("stall_load", 32'(instr_load), 0);
      chk("stall_req", 32'(fetch_req), 0);
      @(negedge clk); cyc++;
    end
    stall = 0;
    fetch_ack = 0;
    #1;
    chk("exec_next", 32'(next_pc), exp_pc);
    chk("exec_state", 32'(state), 2);
    @(negedge clk); cyc++;
    clear_decode();

    m_pc = exp_pc;
    m_ret = (m_ret < 65535) ? m_ret + 1 : 65535;
    #1;
    chk("retired", 32'(retired), m_ret);
    chk("cycles", cyc, 2 + dly + stl);
    chk("post_state", 32'(state), h ? 3 : 1);
    chk("halted", 32'(halted), 32'(h));
    chk("next_fetch_addr", 32'(fetch_addr), m_pc);
  endtask

  // In HALT a start pulse and a stray ack must change nothing.
  task automatic check_halt_frozen();
    start = 1;
    fetch_ack = 1;
    @(negedge clk);
    start = 0;
    fetch_ack = 0;
    @(negedge clk);
    #1;
    chk("halt_state", 32'(state), 3);
    chk("halt_flag", 32'(halted), 1);
    chk("halt_req", 32'(fetch_req), 0);
    chk("halt_pc", 32'(pc), m_pc);
    chk("halt_next", 32'(next_pc), m_pc);
    chk("halt_ret", 32'(retired), m_ret);
  endtask

  initial begin
    vecs[0] = '{8'h10, 1'b0, 1'b1, 1'b0, 1'b0, 8'h80, 8'h80, 2'b01};
    vecs[1] = '{8'h05, 1'b0, 1'b0, 1'b1, 1'b1, 8'hF0, 8'hF6, 2'b01};
    vecs[2] = '{8'h05, 1'b0, 1'b0, 1'b1, 1'b0, 8'hF0, 8'h06, 2'b01};
    vecs[3] = '{8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 2'b01};
    vecs[4] = '{8'h33, 1'b1, 1'b1, 1'b0, 1'b0, 8'h80, 8'h33, 2'b11};
    vecs[5] = '{8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'hFF, 8'h00, 2'b01};
    vecs[6] = '{8'h7F, 1'b0, 1'b0, 1'b1, 1'b1, 8'h7F, 8'hFF, 2'b01};
    vecs[7] = '{8'h20, 1'b0, 1'b1, 1'b1, 1'b1, 8'h40, 8'h40, 2'b01};

    rst = 0; start = 0; fetch_ack = 0; pc_wr = 0; pc_wr_val = 8'h00;
    clear_decode();
    m_pc = 0; m_ret = 0;

    // Reset state, asserted away from any clock edge.
    #1 rst = 1;
    #2;
    chk("rst_state", 32'(state), 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_retired", 32'(retired), 0);
    chk("rst_fetch_req", 32'(fetch_req), 0);
    chk("rst_instr_load", 32'(instr_load), 0);
    chk("rst_next_pc", 32'(next_pc), 0);
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    #1;
    chk("idle_hold_state", 32'(state), 0);
    @(negedge clk);

    // Three plain instructions with immediate ack.
    go();
    for (int i = 0; i < 3; i++) run_instr(0, 0, 0, 0, 0, 0, 8'h00);
    chk("three_retired", 32'(retired), 3);

    // Reset in the middle of a FETCH cycle.
    #2 rst = 1;
    #1;
    chk("midfetch_req", 32'(fetch_req), 0);
    chk("midfetch_state", 32'(state), 0);
    chk("midfetch_ret", 32'(retired), 0);
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("post_rst_idle", 32'(state), 0);
    chk("post_rst_req", 32'(fetch_req), 0);
    @(negedge clk);

    // Decode table: next_pc in EXEC, then state and fetch address after the edge.
    for (int v = 0; v < 8; v++) begin
      do_reset();
      set_pc(vecs[v].pc);
      go();
      fetch_ack = 1;
      @(negedge clk);
      fetch_ack = 0;
      is_halt = vecs[v].h; is_jump = vecs[v].j; is_branch = vecs[v].b;
      br_cond = vecs[v].c; target = vecs[v].tg;
      #1;
      chk($sformatf("vec%0d_next", v), 32'(next_pc), 32'(vecs[v].exp_next));
      @(negedge clk);
      clear_decode();
      #1;
      chk($sformatf("vec%0d_state", v), 32'(state), 32'(vecs[v].exp_state));
      chk($sformatf("vec%0d_addr", v), 32'(fetch_addr), 32'(vecs[v].exp_next));
      @(negedge clk);
    end

    // Slow fetch plus stalls, then halt beating jump and a frozen HALT state.
    do_reset();
    go();
    run_instr(3, 2, 0, 0, 0, 0, 8'h00);
    run_instr(0, 0, 1, 1, 0, 0, 8'h80);
    check_halt_frozen();

    // Random program against the instruction-level model.
    do_reset();
    go();
    for (int n = 0; n < 300; n++) begin
      int dly, stl;
      logic h, j, b, c;
      logic [7:0] tg;
      dly = int'($urandom_range(0, 3));
      stl = int'($urandom_range(0, 2));
      h = ($urandom_range(0, 24) == 0);
      j = ($urandom_range(0, 3) == 0);
      b = 1'($urandom);
      c = 1'($urandom);
      tg = 8'($urandom);
      run_instr(dly, stl, h, j, b, c, tg);
      if (h) begin
        check_halt_frozen();
        do_reset();
        go();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
